// File: rtl/riscv_pkg.sv
// Shared core definitions: address/data widths,
// the canonical NOP and the fetch buffer entry.
package riscv_pkg;

    localparam int INS_ADDRESS = 9;
    localparam int INS_W       = 32;

    localparam logic [INS_W-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [INS_ADDRESS-1:0] pc;
        logic [INS_W-1:0]       instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-side bus: instruction memory read port
// plus the valid/ready handshake towards decode.
interface fetch_stage_if
    import riscv_pkg::*;
#(
    parameter int INS_ADDRESS = riscv_pkg::INS_ADDRESS,
    parameter int INS_W       = riscv_pkg::INS_W
);

    logic [INS_ADDRESS-1:0] imem_ra;
    logic [INS_W-1:0]       imem_rd;
    logic                   out_valid;
    logic                   out_ready;
    logic [INS_W-1:0]       out_instr;
    logic [INS_ADDRESS-1:0] out_pc;

    modport master (
        output imem_ra,
        input  imem_rd,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_ra,
        output imem_rd,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small in-order fetch buffer with flush.
// Caller only pops when non-empty and pushes when not full or popping.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  T              din,
    output T              head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    T              mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    // Pointer and occupancy bookkeeping; flush empties the buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr] <= din;
    end

    assign head  = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, feeds the
// fetch buffer and handles redirects from later stages.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int INS_ADDRESS = riscv_pkg::INS_ADDRESS,
    parameter int INS_W       = riscv_pkg::INS_W,
    parameter int DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    fetch_stage_if.master          bus,
    input  logic                   redirect,
    input  logic [INS_ADDRESS-1:0] redirect_pc,
    output logic                   misalign_err
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [INS_ADDRESS-1:0] pc;
        logic [INS_W-1:0]       instr;
    } entry_t;

    logic [INS_ADDRESS-1:0] pc;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [CW-1:0]          count;
    entry_t                 din;
    entry_t                 head;

    assign pop  = bus.out_valid & bus.out_ready;
    assign push = !redirect & (!full | pop);
    assign din  = '{pc: pc, instr: bus.imem_rd};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redirect),
        .push    (push),
        .pop     (pop & !redirect),
        .din     (din),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // PC update: redirect wins, otherwise advance on every enqueue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc           <= '0;
            misalign_err <= 1'b0;
        end else if (redirect) begin
            pc           <= {redirect_pc[INS_ADDRESS-1:2], 2'b00};
            misalign_err <= misalign_err | (redirect_pc[1:0] != 2'b00);
        end else if (push) begin
            pc <= pc + INS_ADDRESS'(4);
        end
    end

    assign bus.imem_ra   = pc;
    assign bus.out_valid = (count != '0);
    assign bus.out_instr = empty ? NOP_INSTR : head.instr;
    assign bus.out_pc    = empty ? '0 : head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a reference model
// and an expected-delivery queue.
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam int AW    = 9;
    localparam int W     = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [W-1:0]  instr;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          misalign_err;

    exp_t          sb[$];
    logic [AW-1:0] m_pc;
    logic          m_err;
    int            tests = 0;
    int            fails = 0;

    fetch_stage_if #(.INS_ADDRESS(AW), .INS_W(W)) dif ();

    fetch_stage #(
        .INS_ADDRESS (AW),
        .INS_W       (W),
        .DEPTH       (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (dif.master),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] word_of(input logic [AW-1:0] a);
        logic [6:0] idx;
        idx = a[AW-1:2];
        if (idx == 7'd0) return 32'h00007033;
        if (idx == 7'd1) return 32'h00100093;
        return 32'hC0DE0000 | {25'd0, idx};
    endfunction

    assign dif.imem_rd = word_of(dif.imem_ra);

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_pc  = '0;
        m_err = 1'b0;
    endtask

    task automatic model_step();
        bit p;
        bit q;
        if (!reset_n) begin
            model_reset();
        end else if (redirect) begin
            sb.delete();
            m_pc  = {redirect_pc[AW-1:2], 2'b00};
            m_err = m_err | (redirect_pc[1:0] != 2'b00);
        end else begin
            p = (sb.size() != 0) && dif.out_ready;
            q = (sb.size() < DEPTH) || p;
            if (p) void'(sb.pop_front());
            if (q) begin
                sb.push_back('{pc: m_pc, instr: word_of(m_pc)});
                m_pc = m_pc + AW'(4);
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [AW-1:0] epc;
        logic [W-1:0]  ein;
        epc = (sb.size() != 0) ? sb[0].pc : '0;
        ein = (sb.size() != 0) ? sb[0].instr : NOP_INSTR;
        chk({tag, ".valid"}, dif.out_valid, sb.size() != 0);
        chk({tag, ".pc"}, dif.out_pc, epc);
        chk({tag, ".instr"}, dif.out_instr, ein);
        chk({tag, ".ra"}, dif.imem_ra, m_pc);
        chk({tag, ".err"}, misalign_err, m_err);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        redirect = 1'b0;
        model_reset();
        #1;
        check_all("rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        dif.out_ready = 1'b1;
        model_reset();
        #1;
        check_all("rst0");
        chk("rst0.nop", dif.out_instr, 32'h00000013);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // streaming out of reset
        tick("s1");
        chk("s1.pc0", dif.out_pc, 9'h000);
        chk("s1.w0", dif.out_instr, 32'h00007033);
        tick("s2");
        chk("s2.pc4", dif.out_pc, 9'h004);
        chk("s2.w1", dif.out_instr, 32'h00100093);
        tick("s3");
        chk("s3.pc8", dif.out_pc, 9'h008);

        // backpressure saturates the buffer
        do_reset();
        dif.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick("bp");
        chk("bp.ra", dif.imem_ra, 9'h008);
        chk("bp.hold", dif.out_pc, 9'h000);
        dif.out_ready = 1'b1;
        chk("rel.pc0", dif.out_pc, 9'h000);
        tick("rel1");
        chk("rel1.pc4", dif.out_pc, 9'h004);
        tick("rel2");
        chk("rel2.pc8", dif.out_pc, 9'h008);

        // redirect on a full buffer with a live handshake
        do_reset();
        dif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick("fill");
        dif.out_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 9'h040;
        tick("rd0");
        chk("rd0.flush", dif.out_valid, 1'b0);
        redirect = 1'b0;
        tick("rd1");
        chk("rd1.pc", dif.out_pc, 9'h040);
        chk("rd1.w", dif.out_instr, word_of(9'h040));
        tick("rd2");
        chk("rd2.pc", dif.out_pc, 9'h044);

        // PC wrap at the top of the address space
        redirect = 1'b1;
        redirect_pc = 9'h1F8;
        tick("wr0");
        redirect = 1'b0;
        tick("wr1");
        chk("wr1.pc", dif.out_pc, 9'h1F8);
        tick("wr2");
        chk("wr2.pc", dif.out_pc, 9'h1FC);
        tick("wr3");
        chk("wr3.pc", dif.out_pc, 9'h000);
        chk("wr3.nox", $isunknown({dif.out_instr, dif.out_pc}), 1'b0);

        // misaligned redirect target, sticky error
        redirect = 1'b1;
        redirect_pc = 9'h043;
        tick("ma0");
        redirect = 1'b0;
        tick("ma1");
        chk("ma1.pc", dif.out_pc, 9'h040);
        chk("ma1.err", misalign_err, 1'b1);
        redirect = 1'b1;
        redirect_pc = 9'h100;
        tick("ma2");
        redirect = 1'b0;
        tick("ma3");
        chk("ma3.pc", dif.out_pc, 9'h100);
        chk("ma3.err", misalign_err, 1'b1);
        tick("ma4");

        // asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("ar");
        chk("ar.valid", dif.out_valid, 1'b0);
        chk("ar.ra", dif.imem_ra, 9'h000);
        chk("ar.nop", dif.out_instr, 32'h00000013);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick("pr1");
        chk("pr1.pc", dif.out_pc, 9'h000);
        tick("pr2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
